rc4_ctrl: RTL and testbench

//  RC4 engine controller; drives the 3-port S-box RAM (ram: async-read port 1, write port 2, R/W port 3, shared wen).
//  Per start: re-inits S to identity (INIT), runs key schedule (KSA), then streams keystream bytes (PRGA).

---
 rtl/rc4_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_rc4_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rc4_ctrl.sv
// rc4_ctrl: RC4 engine controller driving a 3-port S-box RAM.
// Each start re-initialises S to identity, runs the key schedule, then
// streams keystream bytes on a valid/ready interface.
// Optional feature: define RC4_DROP_EN to discard the first DROP_N bytes.
module rc4_ctrl #(
    parameter int MAX_KEY_BYTES = 16,
    parameter int DROP_N        = 256
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic                               stop,
    input  logic [8*MAX_KEY_BYTES-1:0]         key,
    input  logic [$clog2(MAX_KEY_BYTES+1)-1:0] key_len,
    output logic                               cfg_err,
    output logic                               busy,
    output logic [7:0]                         ks_data,
    output logic                               ks_valid,
    input  logic                               ks_ready,
    output logic [7:0]                         ram_raddr1,
    input  logic [7:0]                         ram_rdata1,
    output logic [7:0]                         ram_addr3,
    input  logic [7:0]                         ram_rdata3,
    output logic [7:0]                         ram_waddr2,
    output logic [7:0]                         ram_wdata2,
    output logic [7:0]                         ram_wdata3,
    output logic                               ram_wen
);

    localparam int KLW = $clog2(MAX_KEY_BYTES + 1);

    if (MAX_KEY_BYTES < 1) begin : g_bad_key_bytes
        $error("rc4_ctrl: MAX_KEY_BYTES must be at least 1");
    end
    if (DROP_N < 0) begin : g_bad_drop_n
        $error("rc4_ctrl: DROP_N must not be negative");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_KSA_RD, S_KSA_SW,
        S_PG_RD, S_PG_SW, S_PG_OUT, S_PG_HOLD
    } state_t;

    state_t                     r_state;
    logic [7:0]                 r_i;
    logic [7:0]                 r_j;
    logic [KLW-1:0]             r_k;
    logic [KLW-1:0]             r_key_len;
    logic [8*MAX_KEY_BYTES-1:0] r_key;
    logic [7:0]                 r_si;
    logic [7:0]                 r_sj;
    logic [7:0]                 r_ks_data;
    logic                       r_ks_valid;
    logic                       r_cfg_err;

    logic                       w_len_ok;
    logic [7:0]                 w_key_byte;
    logic [KLW-1:0]             w_k_next;
    logic                       w_wen;

`ifdef RC4_DROP_EN
    localparam int DW = $clog2(DROP_N + 2);
    logic [DW-1:0]              r_drop_cnt;
`endif

    assign w_len_ok = (key_len != '0) && (key_len <= KLW'(MAX_KEY_BYTES));
    // Key index wraps at key_len-1, avoiding a modulo divider.
    assign w_k_next = (r_k == r_key_len - 1'b1) ? '0 : r_k + 1'b1;

    // Select key byte r_k from the latched key vector.
    always_comb begin
        w_key_byte = '0;
        for (int unsigned n = 0; n < MAX_KEY_BYTES; n++) begin
            if (r_k == n[KLW-1:0]) w_key_byte = r_key[8*n +: 8];
        end
    end

    // RAM addresses, write data and write enable decoded from state/counters.
    always_comb begin
        ram_raddr1 = '0;
        ram_addr3  = '0;
        ram_waddr2 = '0;
        ram_wdata2 = '0;
        ram_wdata3 = '0;
        w_wen      = 1'b0;
        case (r_state)
            S_INIT: begin
                ram_waddr2 = {r_i[6:0], 1'b0};
                ram_wdata2 = {r_i[6:0], 1'b0};
                ram_addr3  = {r_i[6:0], 1'b1};
                ram_wdata3 = {r_i[6:0], 1'b1};
                w_wen      = 1'b1;
            end
            S_KSA_RD, S_PG_RD: ram_addr3 = r_i;
            S_KSA_SW, S_PG_SW: begin
                ram_raddr1 = r_j;
                ram_addr3  = r_i;
                ram_waddr2 = r_j;
                ram_wdata2 = ram_rdata3;
                ram_wdata3 = ram_rdata1;
                w_wen      = 1'b1;
            end
            S_PG_OUT: ram_raddr1 = r_si + r_sj;
            default: ;
        endcase
    end

    // A stop in flight suppresses the write of the current cycle.
    assign ram_wen  = w_wen & ~stop;
    assign busy     = (r_state != S_IDLE);
    assign ks_data  = r_ks_data;
    assign ks_valid = r_ks_valid;
    assign cfg_err  = r_cfg_err;

    // Controller FSM: INIT -> KSA -> PRGA with stop/abort handling.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_i        <= '0;
            r_j        <= '0;
            r_k        <= '0;
            r_key_len  <= '0;
            r_key      <= '0;
            r_si       <= '0;
            r_sj       <= '0;
            r_ks_data  <= '0;
            r_ks_valid <= 1'b0;
            r_cfg_err  <= 1'b0;
`ifdef RC4_DROP_EN
            r_drop_cnt <= '0;
`endif
        end else begin
            r_cfg_err <= 1'b0;
            if (stop && r_state != S_IDLE) begin
                r_state    <= S_IDLE;
                r_ks_valid <= 1'b0;
                r_ks_data  <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start && !stop) begin
                            if (w_len_ok) begin
                                r_key     <= key;
                                r_key_len <= key_len;
                                r_i       <= '0;
                                r_j       <= '0;
                                r_k       <= '0;
`ifdef RC4_DROP_EN
                                r_drop_cnt <= '0;
`endif
                                r_state   <= S_INIT;
                            end else begin
                                r_cfg_err <= 1'b1;
                            end
                        end
                    end
                    S_INIT: begin
                        if (r_i[6:0] == 7'd127) begin
                            r_i     <= '0;
                            r_state <= S_KSA_RD;
                        end else begin
                            r_i <= r_i + 1'b1;
                        end
                    end
                    S_KSA_RD: begin
                        r_j     <= r_j + ram_rdata3 + w_key_byte;
                        r_state <= S_KSA_SW;
                    end
                    S_KSA_SW: begin
                        r_k <= w_k_next;
                        if (r_i == 8'hFF) begin
                            r_i     <= 8'd1;
                            r_j     <= '0;
                            r_state <= S_PG_RD;
                        end else begin
                            r_i     <= r_i + 1'b1;
                            r_state <= S_KSA_RD;
                        end
                    end
                    S_PG_RD: begin
                        r_si    <= ram_rdata3;
                        r_j     <= r_j + ram_rdata3;
                        r_state <= S_PG_SW;
                    end
                    S_PG_SW: begin
                        r_sj    <= ram_rdata1;
                        r_state <= S_PG_OUT;
                    end
                    S_PG_OUT: begin
`ifdef RC4_DROP_EN
                        if (r_drop_cnt != DW'(DROP_N)) begin
                            r_drop_cnt <= r_drop_cnt + 1'b1;
                            r_i        <= r_i + 1'b1;
                            r_state    <= S_PG_RD;
                        end else begin
                            r_ks_data  <= ram_rdata1;
                            r_ks_valid <= 1'b1;
                            r_state    <= S_PG_HOLD;
                        end
`else
                        r_ks_data  <= ram_rdata1;
                        r_ks_valid <= 1'b1;
                        r_state    <= S_PG_HOLD;
`endif
                    end
                    S_PG_HOLD: begin
                        if (ks_ready) begin
                            r_ks_valid <= 1'b0;
                            r_i        <= r_i + 1'b1;
                            r_state    <= S_PG_RD;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rc4_ctrl.sv
// tb_rc4_ctrl: table-driven keystream checks with a byte scoreboard,
// plus hand sequences for cfg errors, reset abort and stop in PG_HOLD.
module tb_rc4_ctrl;

    localparam int MKB = 16;
`ifdef RC4_DROP_EN
    localparam int DROP   = 4;
    localparam int DROP_P = 4;
`else
    localparam int DROP   = 0;
    localparam int DROP_P = 256;
`endif
    localparam int LAT = 644 + 3 * DROP;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic           stop;
    logic [8*MKB-1:0] key;
    logic [4:0]     key_len;
    logic           cfg_err;
    logic           busy;
    logic [7:0]     ks_data;
    logic           ks_valid;
    logic           ks_ready;
    logic [7:0]     ram_raddr1, ram_rdata1, ram_addr3, ram_rdata3;
    logic [7:0]     ram_waddr2, ram_wdata2, ram_wdata3;
    logic           ram_wen;

    rc4_ctrl #(.MAX_KEY_BYTES(MKB), .DROP_N(DROP_P)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .key(key), .key_len(key_len), .cfg_err(cfg_err), .busy(busy),
        .ks_data(ks_data), .ks_valid(ks_valid), .ks_ready(ks_ready),
        .ram_raddr1(ram_raddr1), .ram_rdata1(ram_rdata1),
        .ram_addr3(ram_addr3), .ram_rdata3(ram_rdata3),
        .ram_waddr2(ram_waddr2), .ram_wdata2(ram_wdata2),
        .ram_wdata3(ram_wdata3), .ram_wen(ram_wen)
    );

    int n_vec = 0;
    int n_err = 0;

    // S-box RAM model: async reads, two write ports sharing one enable
    logic [7:0] mem [256];
    assign ram_rdata1 = mem[ram_raddr1];
    assign ram_rdata3 = mem[ram_addr3];
    always @(posedge clk) begin
        if (ram_wen) begin
            if (ram_waddr2 == ram_addr3 && ram_wdata2 != ram_wdata3) begin
                n_err++;
                $display("FAIL ram_collision: addr %0h data2 %0h data3 %0h", ram_addr3, ram_wdata2, ram_wdata3);
            end
            mem[ram_waddr2] <= ram_wdata2;
            mem[ram_addr3]  <= ram_wdata3;
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [8*MKB-1:0] key;
        logic [4:0]       len;
        int               n;
        logic [7:0]       exp [10];
        bit               rnd;
    } vec_t;
    vec_t tbl [4];

    // Scoreboard and handshake monitor
    logic [7:0] q [$];
    bit         sb_en = 0;
    bit         rdy_rand = 0;
    logic       prev_v = 0, prev_r = 0;
    logic [7:0] prev_d = '0;
    logic [7:0] exp_b;

    always @(negedge clk) begin
        if (sb_en && prev_v && !prev_r) begin
            chk("hold_valid", ks_valid, 1);
            chk("hold_data", ks_data, prev_d);
        end
        if (sb_en && ks_valid && ks_ready) begin
            if (q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL extra_byte: got %0h expected none", ks_data);
            end else begin
                exp_b = q.pop_front();
                chk("ks_byte", ks_data, exp_b);
            end
        end
        prev_v = ks_valid;
        prev_r = ks_ready;
        prev_d = ks_data;
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_rand) ks_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic drive_start(input logic [8*MKB-1:0] k, input logic [4:0] l);
        @(posedge clk);
        #1;
        key = k;
        key_len = l;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Called just after the start edge; returns the cycle number of first ks_valid
    task automatic wait_valid(output int lat);
        int cyc = 1;
        lat = -1;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (ks_valid) begin
                lat = cyc;
                break;
            end
            @(posedge clk);
            cyc++;
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_valid"}, ks_valid, 0);
        chk({tag, "_wen"}, ram_wen, 0);
        chk({tag, "_addrs"}, {ram_raddr1, ram_addr3, ram_waddr2}, 0);
    endtask

    task automatic run_vec(input int idx);
        int lat;
        bit tmo;
        sb_en = 1;
        rdy_rand = tbl[idx].rnd;
        if (!tbl[idx].rnd) ks_ready = 1'b1;
        for (int b = DROP; b < tbl[idx].n; b++) q.push_back(tbl[idx].exp[b]);
        drive_start(tbl[idx].key, tbl[idx].len);
        wait_valid(lat);
        chk("latency", lat, LAT);
        tmo = 1;
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk);
            #1;
            if (q.size() == 0) begin
                tmo = 0;
                break;
            end
        end
        chk("drain_timeout", tmo, 0);
        q.delete();
        stop = 1'b1;
        rdy_rand = 0;
        @(posedge clk);
        #1;
        stop = 1'b0;
        @(negedge clk);
        check_idle("after_stop");
        sb_en = 0;
    endtask

    initial begin
        int lat;
        rst_n = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        key = '0;
        key_len = '0;
        ks_ready = 1'b0;

        tbl[0].key = '0; tbl[0].key[23:0] = 24'h79654B; tbl[0].len = 5'd3; tbl[0].n = 10; tbl[0].rnd = 0;
        tbl[0].exp = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72, 8'hA7, 8'h19};
        tbl[1].key = '0; tbl[1].key[31:0] = 32'h696B6957; tbl[1].len = 5'd4; tbl[1].n = 6; tbl[1].rnd = 0;
        tbl[1].exp = '{8'h60, 8'h44, 8'hDB, 8'h6D, 8'h41, 8'hB7, 8'h00, 8'h00, 8'h00, 8'h00};
        tbl[2].key = '0; tbl[2].key[47:0] = 48'h746572636553; tbl[2].len = 5'd6; tbl[2].n = 8; tbl[2].rnd = 0;
        tbl[2].exp = '{8'h04, 8'hD4, 8'h6B, 8'h05, 8'h3C, 8'hA8, 8'h7B, 8'h59, 8'h00, 8'h00};
        tbl[3] = tbl[0];
        tbl[3].rnd = 1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        chk("reset_cfg_err", cfg_err, 0);
        chk("reset_ks_data", ks_data, 0);
        chk("reset_wdata", {ram_wdata2, ram_wdata3}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Keystream vectors, no reset between runs
        for (int v = 0; v < 4; v++) run_vec(v);

        // Illegal key lengths
        for (int v = 0; v < 2; v++) begin
            drive_start(tbl[0].key, (v == 0) ? 5'd0 : 5'd17);
            @(negedge clk);
            chk("cfg_err_pulse", cfg_err, 1);
            chk("cfg_err_busy", busy, 0);
            chk("cfg_err_wen", ram_wen, 0);
            @(negedge clk);
            chk("cfg_err_clear", cfg_err, 0);
            chk("cfg_err_busy2", busy, 0);
            chk("cfg_err_wen2", ram_wen, 0);
        end

        // start together with stop in IDLE is ignored
        @(posedge clk);
        #1;
        key = tbl[0].key;
        key_len = 5'd3;
        start = 1'b1;
        stop = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        stop = 1'b0;
        @(negedge clk);
        chk("start_stop_busy", busy, 0);
        chk("start_stop_cfg", cfg_err, 0);

        // Reset in the middle of KSA (cycle 300 of the schedule)
        ks_ready = 1'b1;
        drive_start(tbl[0].key, 5'd3);
        repeat (428) @(posedge clk);
        #1;
        @(negedge clk);
        chk("mid_ksa_busy", busy, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_idle("mid_reset");
        chk("mid_reset_data", ks_data, 0);
        chk("mid_reset_cfg", cfg_err, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_vec(0);

        // Stop while holding a byte; stop beats ks_ready
        ks_ready = 1'b0;
        drive_start(tbl[0].key, 5'd3);
        wait_valid(lat);
        chk("hold_latency", lat, LAT);
        chk("hold_first", ks_data, tbl[0].exp[DROP]);
        @(posedge clk);
        @(negedge clk);
        chk("hold_stay_valid", ks_valid, 1);
        chk("hold_stay_data", ks_data, tbl[0].exp[DROP]);
        @(posedge clk);
        #1;
        stop = 1'b1;
        ks_ready = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
        @(negedge clk);
        check_idle("hold_stop");
        chk("hold_stop_data", ks_data, 0);
        run_vec(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
